// File: rtl/bp_fe_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// bp_fe_fetch_sequencer
//
// Front-end fetch sequencer. Issues one virtual PC per cycle to the icache,
// tags it for one cycle, then either enqueues it into the fetch queue when
// its response comes back good, or reissues it later after an icache miss
// or a fetch-queue refusal. Backend redirects and taken predictions steer
// the next PC.
//
// Parameters
//   vaddr_width_p  virtual PC width in bits
//   bp_first_pc_p  first PC issued after reset
//
// Ports
//   clk_i             rising-edge clock
//   reset_i           synchronous active-high reset
//   redirect_v_i      backend redirect valid
//   redirect_pc_i     redirect target
//   redirect_ready_o  redirect accepted this cycle when valid and aligned
//   pred_v_i          predictor has a taken target for this cycle's response
//   pred_pc_i         predicted taken target
//   icache_v_o        fetch issue valid
//   icache_pc_o       fetch issue PC
//   icache_ready_i    icache accepts the issue
//   icache_data_v_i   response valid for the PC issued last cycle
//   icache_miss_i     that response missed
//   fe_queue_v_o      enqueue valid
//   fe_queue_pc_o     enqueued PC
//   fe_queue_ready_i  fetch queue accepts the enqueue
//   misaligned_o      pulse when a redirect target has pc[1:0] != 0
//
// Issue and enqueue outputs are combinational: a good response with a
// prediction must steer the issue in the same cycle, so they cannot be
// registered.
// ---------------------------------------------------------------------------
module bp_fe_fetch_sequencer #(
    parameter int                       vaddr_width_p = 32,
    parameter logic [vaddr_width_p-1:0] bp_first_pc_p = vaddr_width_p'(32'h8000_0000)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     redirect_v_i,
    input  logic [vaddr_width_p-1:0] redirect_pc_i,
    output logic                     redirect_ready_o,

    input  logic                     pred_v_i,
    input  logic [vaddr_width_p-1:0] pred_pc_i,

    output logic                     icache_v_o,
    output logic [vaddr_width_p-1:0] icache_pc_o,
    input  logic                     icache_ready_i,

    input  logic                     icache_data_v_i,
    input  logic                     icache_miss_i,

    output logic                     fe_queue_v_o,
    output logic [vaddr_width_p-1:0] fe_queue_pc_o,
    input  logic                     fe_queue_ready_i,

    output logic                     misaligned_o
);

    typedef enum logic [1:0] {
        e_boot   = 2'd0,
        e_run    = 2'd1,
        e_miss   = 2'd2,
        e_replay = 2'd3
    } state_e;

    localparam logic [vaddr_width_p-1:0] pc_zero_c = {vaddr_width_p{1'b0}};
    localparam logic [vaddr_width_p-1:0] pc_step_c = vaddr_width_p'(3'd4);

    state_e                   state_r;
    state_e                   state_n;

    logic [vaddr_width_p-1:0] pc_r;
    logic [vaddr_width_p-1:0] tl_pc_r;
    logic                     tl_v_r;
    logic [vaddr_width_p-1:0] miss_pc_r;
    logic [vaddr_width_p-1:0] pending_pc_r;
    logic                     pending_v_r;
    logic                     kill_r;

    logic                     aligned_s;
    logic                     redirect_ready_s;
    logic                     redir_acc_s;
    logic                     misaligned_s;
    logic                     squash_s;
    logic                     resp_live_s;
    logic                     resp_good_s;
    logic                     resp_miss_s;
    logic                     enq_fail_s;
    logic                     issue_v_s;
    logic                     issue_s;
    logic                     issue_commit_s;
    logic [vaddr_width_p-1:0] issue_pc_s;

    // Redirect acceptance: only aligned targets are taken; while a redirect
    // is still waiting to issue, further redirects are held off.
    assign aligned_s        = (redirect_pc_i[1:0] == 2'b00);
    assign redirect_ready_s = ~reset_i & ~pending_v_r;
    assign redir_acc_s      = redirect_v_i & redirect_ready_s & aligned_s;
    assign misaligned_s     = redirect_v_i & redirect_ready_s & ~aligned_s;

    // The response arriving in a redirect cycle belongs to the old stream and
    // is squashed immediately; kill_r extends that to the next cycle when the
    // redirect target could not issue right away. A squashed response can
    // neither miss nor enqueue, which is what gives the redirect priority
    // over a simultaneous miss or queue refusal.
    assign squash_s    = redir_acc_s | kill_r;
    assign resp_live_s = ~reset_i & icache_data_v_i & tl_v_r & ~squash_s;
    assign resp_good_s = resp_live_s & ~icache_miss_i;
    assign resp_miss_s = resp_live_s & icache_miss_i;
    assign enq_fail_s  = resp_good_s & ~fe_queue_ready_i;

    // Only issue when the queue can take the result, so a refused enqueue
    // never has a younger fetch behind it.
    assign issue_v_s      = ~reset_i & (state_r != e_boot) & fe_queue_ready_i;
    assign issue_s        = issue_v_s & icache_ready_i;
    // An issue in the same cycle as a miss is discarded: the missed PC is
    // refetched first and pc_r stays where it was.
    assign issue_commit_s = issue_s & ~resp_miss_s;

    // Next fetch PC by strict priority.
    always_comb begin
        issue_pc_s = pc_r;
        if (reset_i) begin
            issue_pc_s = pc_zero_c;
        end else if (redir_acc_s) begin
            issue_pc_s = redirect_pc_i;
        end else if (pending_v_r) begin
            issue_pc_s = pending_pc_r;
        end else if ((state_r == e_miss) || (state_r == e_replay)) begin
            issue_pc_s = miss_pc_r;
        end else if (resp_good_s && pred_v_i) begin
            issue_pc_s = pred_pc_i;
        end else begin
            issue_pc_s = pc_r;
        end
    end

    // Next-state logic; a redirect always returns the sequencer to e_run.
    always_comb begin
        state_n = state_r;
        if (redir_acc_s) begin
            state_n = e_run;
        end else begin
            case (state_r)
                e_boot: begin
                    state_n = e_run;
                end
                e_run, e_miss, e_replay: begin
                    if (resp_miss_s) begin
                        state_n = e_miss;
                    end else if (enq_fail_s) begin
                        state_n = e_replay;
                    end else if (issue_s) begin
                        state_n = e_run;
                    end else begin
                        state_n = state_r;
                    end
                end
                default: begin
                    state_n = e_boot;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_boot;
        end else begin
            state_r <= state_n;
        end
    end

    // Sequential PC and the tag of the PC issued last cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_r    <= bp_first_pc_p;
            tl_pc_r <= pc_zero_c;
            tl_v_r  <= 1'b0;
        end else begin
            tl_v_r <= issue_commit_s;
            if (issue_commit_s) begin
                pc_r    <= issue_pc_s + pc_step_c;
                tl_pc_r <= issue_pc_s;
            end else begin
                pc_r    <= pc_r;
                tl_pc_r <= tl_pc_r;
            end
        end
    end

    // PC to refetch after a miss or a refused enqueue.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            miss_pc_r <= pc_zero_c;
        end else if (resp_miss_s || enq_fail_s) begin
            miss_pc_r <= tl_pc_r;
        end else begin
            miss_pc_r <= miss_pc_r;
        end
    end

    // Redirect target held until the icache takes it, plus the squash flag.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pending_pc_r <= pc_zero_c;
            pending_v_r  <= 1'b0;
            kill_r       <= 1'b0;
        end else begin
            kill_r <= redir_acc_s & ~issue_s;
            if (redir_acc_s && !issue_s) begin
                pending_pc_r <= redirect_pc_i;
                pending_v_r  <= 1'b1;
            end else if (pending_v_r && issue_s) begin
                pending_pc_r <= pending_pc_r;
                pending_v_r  <= 1'b0;
            end else begin
                pending_pc_r <= pending_pc_r;
                pending_v_r  <= pending_v_r;
            end
        end
    end

    assign redirect_ready_o = redirect_ready_s;
    assign misaligned_o     = misaligned_s;
    assign icache_v_o       = issue_v_s;
    assign icache_pc_o      = issue_pc_s;
    assign fe_queue_v_o     = resp_good_s;
    assign fe_queue_pc_o    = reset_i ? pc_zero_c : tl_pc_r;

endmodule

// File: tb/tb_bp_fe_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bp_fe_fetch_sequencer
//
// Directed bench for the fetch sequencer. Inputs change 1 time unit after
// the rising edge; outputs are compared on the falling edge. Cycle C0 is the
// first cycle with reset low (FSM in e_boot); C1 is the first issue.
// ---------------------------------------------------------------------------
module tb_bp_fe_fetch_sequencer;

    localparam int          W     = 32;
    localparam logic [31:0] FIRST = 32'h8000_0000;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          redirect_v_i;
    logic [W-1:0]  redirect_pc_i;
    logic          redirect_ready_o;
    logic          pred_v_i;
    logic [W-1:0]  pred_pc_i;
    logic          icache_v_o;
    logic [W-1:0]  icache_pc_o;
    logic          icache_ready_i;
    logic          icache_data_v_i;
    logic          icache_miss_i;
    logic          fe_queue_v_o;
    logic [W-1:0]  fe_queue_pc_o;
    logic          fe_queue_ready_i;
    logic          misaligned_o;

    int nvec = 0;
    int nerr = 0;

    bp_fe_fetch_sequencer #(
        .vaddr_width_p (W),
        .bp_first_pc_p (FIRST)
    ) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .redirect_v_i     (redirect_v_i),
        .redirect_pc_i    (redirect_pc_i),
        .redirect_ready_o (redirect_ready_o),
        .pred_v_i         (pred_v_i),
        .pred_pc_i        (pred_pc_i),
        .icache_v_o       (icache_v_o),
        .icache_pc_o      (icache_pc_o),
        .icache_ready_i   (icache_ready_i),
        .icache_data_v_i  (icache_data_v_i),
        .icache_miss_i    (icache_miss_i),
        .fe_queue_v_o     (fe_queue_v_o),
        .fe_queue_pc_o    (fe_queue_pc_o),
        .fe_queue_ready_i (fe_queue_ready_i),
        .misaligned_o     (misaligned_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_idle();
        redirect_v_i     = 1'b0;
        redirect_pc_i    = 32'h0;
        pred_v_i         = 1'b0;
        pred_pc_i        = 32'h0;
        icache_ready_i   = 1'b1;
        icache_data_v_i  = 1'b1;
        icache_miss_i    = 1'b0;
        fe_queue_ready_i = 1'b1;
    endtask

    // Leaves the bench in C0 (reset just released, FSM in e_boot).
    task automatic do_reset();
        set_idle();
        reset_i = 1'b1;
        next_cycle();
        next_cycle();
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        reset_i       = 1'b1;
        redirect_v_i  = 1'b1;
        redirect_pc_i = 32'h8000_0002;
        next_cycle();
        next_cycle();
        @(negedge clk_i);
        nvec++; if (icache_v_o !== 1'b0) begin nerr++; $display("FAIL rst_icache_v: got %b want 0", icache_v_o); end
        nvec++; if (icache_pc_o !== 32'h0) begin nerr++; $display("FAIL rst_icache_pc: got %h want 0", icache_pc_o); end
        nvec++; if (fe_queue_v_o !== 1'b0) begin nerr++; $display("FAIL rst_fq_v: got %b want 0", fe_queue_v_o); end
        nvec++; if (fe_queue_pc_o !== 32'h0) begin nerr++; $display("FAIL rst_fq_pc: got %h want 0", fe_queue_pc_o); end
        nvec++; if (redirect_ready_o !== 1'b0) begin nerr++; $display("FAIL rst_redir_rdy: got %b want 0", redirect_ready_o); end
        nvec++; if (misaligned_o !== 1'b0) begin nerr++; $display("FAIL rst_misaligned: got %b want 0", misaligned_o); end
        next_cycle();
        reset_i      = 1'b0;
        redirect_v_i = 1'b0;
        @(negedge clk_i);
        nvec++; if (icache_v_o !== 1'b0) begin nerr++; $display("FAIL boot_no_issue: got %b want 0", icache_v_o); end
        nvec++; if (redirect_ready_o !== 1'b1) begin nerr++; $display("FAIL boot_redir_rdy: got %b want 1", redirect_ready_o); end
        next_cycle();
        @(negedge clk_i);
        nvec++; if (icache_v_o !== 1'b1) begin nerr++; $display("FAIL first_issue_v: got %b want 1", icache_v_o); end
        nvec++; if (icache_pc_o !== FIRST) begin nerr++; $display("FAIL first_issue_pc: got %h want %h", icache_pc_o, FIRST); end
    endtask

    task automatic test_boot_stream();
        logic [31:0] e_pc;
        logic [31:0] e_qpc;
        do_reset();
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            e_pc  = FIRST + 32'(4 * i);
            e_qpc = FIRST + 32'(4 * (i - 1));
            @(negedge clk_i);
            nvec++; if (icache_v_o !== 1'b1 || icache_pc_o !== e_pc) begin nerr++; $display("FAIL stream_issue[%0d]: got v=%b pc=%h want v=1 pc=%h", i, icache_v_o, icache_pc_o, e_pc); end
            nvec++; if (fe_queue_v_o !== (i > 0)) begin nerr++; $display("FAIL stream_enq_v[%0d]: got %b want %b", i, fe_queue_v_o, (i > 0)); end
            if (i > 0) begin
                nvec++; if (fe_queue_pc_o !== e_qpc) begin nerr++; $display("FAIL stream_enq_pc[%0d]: got %h want %h", i, fe_queue_pc_o, e_qpc); end
            end
            next_cycle();
        end
    endtask

    task automatic test_miss();
        do_reset();
        repeat (3) next_cycle();
        icache_miss_i = 1'b1;
        @(negedge clk_i);
        nvec++; if (fe_queue_v_o !== 1'b0) begin nerr++; $display("FAIL miss_no_enq: got %b want 0", fe_queue_v_o); end
        next_cycle();
        icache_miss_i  = 1'b0;
        icache_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            nvec++; if (icache_v_o !== 1'b1 || icache_pc_o !== 32'h8000_0004) begin nerr++; $display("FAIL miss_hold[%0d]: got v=%b pc=%h want v=1 pc=80000004", k, icache_v_o, icache_pc_o); end
            nvec++; if (fe_queue_v_o !== 1'b0) begin nerr++; $display("FAIL miss_hold_enq[%0d]: got %b want 0", k, fe_queue_v_o); end
            next_cycle();
        end
        icache_ready_i = 1'b1;
        @(negedge clk_i);
        nvec++; if (icache_pc_o !== 32'h8000_0004) begin nerr++; $display("FAIL miss_reissue: got %h want 80000004", icache_pc_o); end
        next_cycle();
        @(negedge clk_i);
        nvec++; if (icache_pc_o !== 32'h8000_0008) begin nerr++; $display("FAIL miss_after_pc: got %h want 80000008", icache_pc_o); end
        nvec++; if (fe_queue_v_o !== 1'b1 || fe_queue_pc_o !== 32'h8000_0004) begin nerr++; $display("FAIL miss_enq: got v=%b pc=%h want v=1 pc=80000004", fe_queue_v_o, fe_queue_pc_o); end
        next_cycle();
        @(negedge clk_i);
        nvec++; if (fe_queue_pc_o !== 32'h8000_0008 || icache_pc_o !== 32'h8000_000C) begin nerr++; $display("FAIL miss_resume: got q=%h i=%h want q=80000008 i=8000000c", fe_queue_pc_o, icache_pc_o); end
    endtask

    task automatic test_redirect_in_miss();
        do_reset();
        repeat (3) next_cycle();
        icache_miss_i  = 1'b1;
        icache_ready_i = 1'b0;
        next_cycle();
        icache_miss_i = 1'b0;
        redirect_v_i  = 1'b1;
        redirect_pc_i = 32'h8000_1000;
        @(negedge clk_i);
        nvec++; if (redirect_ready_o !== 1'b1) begin nerr++; $display("FAIL rim_ready: got %b want 1", redirect_ready_o); end
        nvec++; if (icache_pc_o !== 32'h8000_1000) begin nerr++; $display("FAIL rim_pc_acc: got %h want 80001000", icache_pc_o); end
        nvec++; if (fe_queue_v_o !== 1'b0) begin nerr++; $display("FAIL rim_stale_enq: got %b want 0", fe_queue_v_o); end
        next_cycle();
        redirect_v_i = 1'b0;
        @(negedge clk_i);
        nvec++; if (redirect_ready_o !== 1'b0) begin nerr++; $display("FAIL rim_pending_rdy: got %b want 0", redirect_ready_o); end
        nvec++; if (icache_pc_o !== 32'h8000_1000 || fe_queue_v_o !== 1'b0) begin nerr++; $display("FAIL rim_pending_pc: got pc=%h qv=%b want pc=80001000 qv=0", icache_pc_o, fe_queue_v_o); end
        next_cycle();
        icache_ready_i = 1'b1;
        @(negedge clk_i);
        nvec++; if (icache_v_o !== 1'b1 || icache_pc_o !== 32'h8000_1000) begin nerr++; $display("FAIL rim_first_issue: got v=%b pc=%h want v=1 pc=80001000", icache_v_o, icache_pc_o); end
        nvec++; if (fe_queue_v_o !== 1'b0) begin nerr++; $display("FAIL rim_first_enq: got %b want 0", fe_queue_v_o); end
        next_cycle();
        @(negedge clk_i);
        nvec++; if (icache_pc_o !== 32'h8000_1004) begin nerr++; $display("FAIL rim_next_pc: got %h want 80001004", icache_pc_o); end
        nvec++; if (fe_queue_v_o !== 1'b1 || fe_queue_pc_o !== 32'h8000_1000) begin nerr++; $display("FAIL rim_enq: got v=%b pc=%h want v=1 pc=80001000", fe_queue_v_o, fe_queue_pc_o); end
        nvec++; if (redirect_ready_o !== 1'b1) begin nerr++; $display("FAIL rim_rdy_back: got %b want 1", redirect_ready_o); end
    endtask

    task automatic test_predict();
        do_reset();
        repeat (6) next_cycle();
        pred_v_i  = 1'b1;
        pred_pc_i = 32'h8000_0200;
        @(negedge clk_i);
        nvec++; if (icache_pc_o !== 32'h8000_0200) begin nerr++; $display("FAIL pred_issue: got %h want 80000200", icache_pc_o); end
        nvec++; if (fe_queue_v_o !== 1'b1 || fe_queue_pc_o !== 32'h8000_0010) begin nerr++; $display("FAIL pred_enq: got v=%b pc=%h want v=1 pc=80000010", fe_queue_v_o, fe_queue_pc_o); end
        next_cycle();
        pred_v_i = 1'b0;
        @(negedge clk_i);
        nvec++; if (icache_pc_o !== 32'h8000_0204 || fe_queue_pc_o !== 32'h8000_0200) begin nerr++; $display("FAIL pred_follow: got i=%h q=%h want i=80000204 q=80000200", icache_pc_o, fe_queue_pc_o); end
        next_cycle();
        icache_miss_i = 1'b1;
        pred_v_i      = 1'b1;
        pred_pc_i     = 32'h8000_0300;
        @(negedge clk_i);
        nvec++; if (icache_pc_o !== 32'h8000_0208) begin nerr++; $display("FAIL pred_on_miss: got %h want 80000208", icache_pc_o); end
        next_cycle();
        icache_miss_i = 1'b0;
        pred_v_i      = 1'b0;
        @(negedge clk_i);
        nvec++; if (icache_pc_o !== 32'h8000_0204) begin nerr++; $display("FAIL pred_miss_refetch: got %h want 80000204", icache_pc_o); end
    endtask

    task automatic test_backpressure();
        do_reset();
        repeat (3) next_cycle();
        fe_queue_ready_i = 1'b0;
        @(negedge clk_i);
        nvec++; if (icache_v_o !== 1'b0) begin nerr++; $display("FAIL bp_no_issue: got %b want 0", icache_v_o); end
        nvec++; if (fe_queue_v_o !== 1'b1 || fe_queue_pc_o !== 32'h8000_0004) begin nerr++; $display("FAIL bp_enq_offer: got v=%b pc=%h want v=1 pc=80000004", fe_queue_v_o, fe_queue_pc_o); end
        next_cycle();
        fe_queue_ready_i = 1'b1;
        @(negedge clk_i);
        nvec++; if (icache_v_o !== 1'b1 || icache_pc_o !== 32'h8000_0004 || fe_queue_v_o !== 1'b0) begin nerr++; $display("FAIL bp_replay: got v=%b pc=%h qv=%b want v=1 pc=80000004 qv=0", icache_v_o, icache_pc_o, fe_queue_v_o); end
        next_cycle();
        @(negedge clk_i);
        nvec++; if (icache_pc_o !== 32'h8000_0008 || fe_queue_v_o !== 1'b1 || fe_queue_pc_o !== 32'h8000_0004) begin nerr++; $display("FAIL bp_replay_enq: got i=%h qv=%b q=%h want i=80000008 qv=1 q=80000004", icache_pc_o, fe_queue_v_o, fe_queue_pc_o); end
        next_cycle();
        @(negedge clk_i);
        nvec++; if (icache_pc_o !== 32'h8000_000C || fe_queue_pc_o !== 32'h8000_0008) begin nerr++; $display("FAIL bp_resume: got i=%h q=%h want i=8000000c q=80000008", icache_pc_o, fe_queue_pc_o); end
        next_cycle();
        redirect_v_i  = 1'b1;
        redirect_pc_i = 32'h8000_0002;
        @(negedge clk_i);
        nvec++; if (misaligned_o !== 1'b1 || redirect_ready_o !== 1'b1) begin nerr++; $display("FAIL misal_pulse: got mis=%b rdy=%b want mis=1 rdy=1", misaligned_o, redirect_ready_o); end
        nvec++; if (icache_pc_o !== 32'h8000_0010 || fe_queue_pc_o !== 32'h8000_000C) begin nerr++; $display("FAIL misal_stream: got i=%h q=%h want i=80000010 q=8000000c", icache_pc_o, fe_queue_pc_o); end
        next_cycle();
        redirect_v_i = 1'b0;
        @(negedge clk_i);
        nvec++; if (misaligned_o !== 1'b0) begin nerr++; $display("FAIL misal_drop: got %b want 0", misaligned_o); end
        nvec++; if (icache_pc_o !== 32'h8000_0014 || fe_queue_pc_o !== 32'h8000_0010) begin nerr++; $display("FAIL misal_after: got i=%h q=%h want i=80000014 q=80000010", icache_pc_o, fe_queue_pc_o); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        repeat (3) next_cycle();
        icache_miss_i = 1'b1;
        redirect_v_i  = 1'b1;
        redirect_pc_i = 32'h8000_2000;
        @(negedge clk_i);
        nvec++; if (icache_pc_o !== 32'h8000_2000 || fe_queue_v_o !== 1'b0) begin nerr++; $display("FAIL b2b_redir_wins: got i=%h qv=%b want i=80002000 qv=0", icache_pc_o, fe_queue_v_o); end
        next_cycle();
        icache_miss_i = 1'b0;
        redirect_v_i  = 1'b0;
        @(negedge clk_i);
        nvec++; if (icache_pc_o !== 32'h8000_2004) begin nerr++; $display("FAIL b2b_no_miss: got %h want 80002004", icache_pc_o); end
        nvec++; if (fe_queue_v_o !== 1'b1 || fe_queue_pc_o !== 32'h8000_2000) begin nerr++; $display("FAIL b2b_target_enq: got v=%b pc=%h want v=1 pc=80002000", fe_queue_v_o, fe_queue_pc_o); end
        next_cycle();
        redirect_v_i  = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        @(negedge clk_i);
        nvec++; if (icache_pc_o !== 32'hFFFF_FFFC || fe_queue_v_o !== 1'b0) begin nerr++; $display("FAIL b2b_second_redir: got i=%h qv=%b want i=fffffffc qv=0", icache_pc_o, fe_queue_v_o); end
        next_cycle();
        redirect_v_i = 1'b0;
        @(negedge clk_i);
        nvec++; if (icache_pc_o !== 32'h0000_0000) begin nerr++; $display("FAIL b2b_wrap: got %h want 00000000", icache_pc_o); end
        nvec++; if (fe_queue_v_o !== 1'b1 || fe_queue_pc_o !== 32'hFFFF_FFFC) begin nerr++; $display("FAIL b2b_wrap_enq: got v=%b pc=%h want v=1 pc=fffffffc", fe_queue_v_o, fe_queue_pc_o); end
    endtask

    task automatic test_reset_mid_miss();
        do_reset();
        repeat (3) next_cycle();
        icache_miss_i  = 1'b1;
        icache_ready_i = 1'b0;
        next_cycle();
        icache_miss_i = 1'b0;
        redirect_v_i  = 1'b1;
        redirect_pc_i = 32'h8000_3000;
        next_cycle();
        redirect_v_i = 1'b0;
        reset_i      = 1'b1;
        @(negedge clk_i);
        nvec++; if (icache_v_o !== 1'b0 || redirect_ready_o !== 1'b0 || fe_queue_v_o !== 1'b0) begin nerr++; $display("FAIL rmm_in_reset: got iv=%b rdy=%b qv=%b want 0 0 0", icache_v_o, redirect_ready_o, fe_queue_v_o); end
        next_cycle();
        reset_i        = 1'b0;
        icache_ready_i = 1'b1;
        @(negedge clk_i);
        nvec++; if (icache_v_o !== 1'b0 || redirect_ready_o !== 1'b1) begin nerr++; $display("FAIL rmm_boot: got iv=%b rdy=%b want iv=0 rdy=1", icache_v_o, redirect_ready_o); end
        next_cycle();
        @(negedge clk_i);
        nvec++; if (icache_v_o !== 1'b1 || icache_pc_o !== FIRST) begin nerr++; $display("FAIL rmm_first: got v=%b pc=%h want v=1 pc=%h", icache_v_o, icache_pc_o, FIRST); end
    endtask

    initial begin
        reset_i = 1'b1;
        set_idle();
        test_reset();
        test_boot_stream();
        test_miss();
        test_redirect_in_miss();
        test_predict();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_miss();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
